// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared types and constants for the ghost mode scheduler.
package ghost_mode_scheduler_pkg;

   localparam int NUM_GHOSTS_DEFAULT = 4;

   // Last phase index; it is a chase phase that never expires.
   localparam logic [2:0] PHASE_LAST = 3'd7;

   // Externally visible mode codes.
   typedef enum logic [1:0] {
      MODE_IDLE    = 2'd0,
      MODE_SCATTER = 2'd1,
      MODE_CHASE   = 2'd2,
      MODE_FRIGHT  = 2'd3
   } mode_e;

   // Controller state; scatter versus chase is taken from the phase index.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FRIGHT = 2'd2
   } state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ghost_mode_scheduler_prescaler.sv
// Move-tick prescaler: one tick every TICK_DIV enabled cycles.
module ghost_mode_scheduler_prescaler
   import ghost_mode_scheduler_pkg::*;
#(
   parameter int TICK_DIV = 19
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic enable_i,
   output logic tick_o
);

   localparam int CW = cnt_width(TICK_DIV - 1);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = enable_i & (cnt_q == LAST);

   // Count while enabled, wrap after the tick; park at zero when disabled.
   always_comb begin
      cnt_d = '0;
      if (enable_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Central ghost sequencer: move strobes, scatter/chase/fright phases, house release.
module ghost_mode_scheduler
   import ghost_mode_scheduler_pkg::*;
#(
   parameter int NUM_GHOSTS    = NUM_GHOSTS_DEFAULT,
   parameter int TICK_DIV      = 19,
   parameter int SCATTER_TICKS = 35,
   parameter int CHASE_TICKS   = 100,
   parameter int FRIGHT_TICKS  = 30,
   parameter int BLINK_TICKS   = 8,
   parameter int RELEASE_GAP   = 10
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  game_start_i,
   input  logic                  player_dead_i,
   input  logic                  power_pellet_i,
   input  logic [NUM_GHOSTS-1:0] ghost_eaten_i,
   output logic [NUM_GHOSTS-1:0] move_en_o,
   output logic [1:0]            mode_o,
   output logic [NUM_GHOSTS-1:0] frightened_o,
   output logic                  fright_ending_o,
   output logic [NUM_GHOSTS-1:0] released_o
);

   localparam int PH_MAX  = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
   localparam int PH_W    = cnt_width(PH_MAX);
   localparam int FR_W    = cnt_width(FRIGHT_TICKS);
   localparam int REL_MAX = (NUM_GHOSTS - 1) * RELEASE_GAP;
   localparam int REL_W   = cnt_width(REL_MAX);

   localparam logic [PH_W-1:0]  SC_LAST  = PH_W'(SCATTER_TICKS - 1);
   localparam logic [PH_W-1:0]  CH_LAST  = PH_W'(CHASE_TICKS - 1);
   localparam logic [FR_W-1:0]  FR_LOAD  = FR_W'(FRIGHT_TICKS);
   localparam logic [FR_W-1:0]  FR_BLINK = FR_W'(BLINK_TICKS);
   localparam logic [REL_W-1:0] REL_SAT  = REL_W'(REL_MAX);

   state_e                  state_q, state_d;
   logic [2:0]              phase_q, phase_d;
   logic [PH_W-1:0]         ph_cnt_q, ph_cnt_d, ph_last;
   logic [FR_W-1:0]         fr_tmr_q, fr_tmr_d;
   logic [REL_W-1:0]        rel_cnt_q, rel_cnt_d;
   logic                    half_q, half_d;
   logic [NUM_GHOSTS-1:0]   released_q, released_d;
   logic [NUM_GHOSTS-1:0]   frightened_q, frightened_d;
   logic [NUM_GHOSTS-1:0]   move_q, move_d;
   logic [NUM_GHOSTS-1:0]   fr_nxt;
   logic                    tick, run_en, fr_timeout;

   // A death cycle already counts as idle so no tick can escape it.
   assign run_en = (state_q != ST_IDLE) & ~player_dead_i;

   ghost_mode_scheduler_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .enable_i (run_en),
      .tick_o   (tick)
   );

   // Fright events: eaten bits beat a simultaneous pellet; a pellet beats expiry.
   always_comb begin
      fr_nxt = frightened_q & ~ghost_eaten_i;
      if (power_pellet_i) fr_nxt = (frightened_q | released_q) & ~ghost_eaten_i;
      fr_timeout = tick & ~power_pellet_i & (fr_tmr_q == FR_W'(1));
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // FSM next state; death overrides everything.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (game_start_i) state_d = ST_RUN;
         ST_RUN:    if (power_pellet_i && |fr_nxt) state_d = ST_FRIGHT;
         ST_FRIGHT: if (~|fr_nxt || fr_timeout) state_d = ST_RUN;
         default:   state_d = ST_IDLE;
      endcase
      if (player_dead_i) state_d = ST_IDLE;
   end

   // FSM outputs: mode code and the blink warning.
   always_comb begin
      mode_o          = MODE_IDLE;
      fright_ending_o = 1'b0;
      case (state_q)
         ST_RUN:    mode_o = phase_q[0] ? MODE_CHASE : MODE_SCATTER;
         ST_FRIGHT: begin
            mode_o          = MODE_FRIGHT;
            fright_ending_o = (fr_tmr_q <= FR_BLINK);
         end
         default:   mode_o = MODE_IDLE;
      endcase
   end

   // Timers and ghost masks; phase and release counters freeze during fright.
   always_comb begin
      phase_d      = phase_q;
      ph_cnt_d     = ph_cnt_q;
      fr_tmr_d     = fr_tmr_q;
      rel_cnt_d    = rel_cnt_q;
      half_d       = half_q;
      released_d   = released_q;
      frightened_d = frightened_q;
      ph_last      = phase_q[0] ? CH_LAST : SC_LAST;
      move_d       = tick ? (released_q & (~frightened_q | {NUM_GHOSTS{half_q}})) : '0;

      if (player_dead_i) begin
         phase_d      = '0;
         ph_cnt_d     = '0;
         fr_tmr_d     = '0;
         rel_cnt_d    = '0;
         half_d       = 1'b0;
         released_d   = '0;
         frightened_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (game_start_i) begin
                  phase_d    = '0;
                  ph_cnt_d   = '0;
                  rel_cnt_d  = '0;
                  released_d = NUM_GHOSTS'(1);
               end
            end
            ST_RUN: begin
               if (tick) begin
                  if (rel_cnt_q != REL_SAT) rel_cnt_d = rel_cnt_q + REL_W'(1);
                  for (int k = 0; k < NUM_GHOSTS; k++)
                     if (rel_cnt_d == REL_W'(k * RELEASE_GAP)) released_d[k] = 1'b1;
                  if (phase_q != PHASE_LAST) begin
                     if (ph_cnt_q == ph_last) begin
                        phase_d  = phase_q + 3'd1;
                        ph_cnt_d = '0;
                     end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                     end
                  end
               end
               if (state_d == ST_FRIGHT) begin
                  frightened_d = fr_nxt;
                  fr_tmr_d     = FR_LOAD;
                  half_d       = 1'b0;
               end
            end
            ST_FRIGHT: begin
               frightened_d = fr_nxt;
               if (power_pellet_i) fr_tmr_d = FR_LOAD;
               else if (tick)      fr_tmr_d = fr_tmr_q - FR_W'(1);
               if (tick) half_d = ~half_q;
               if (state_d == ST_RUN) begin
                  frightened_d = '0;
                  fr_tmr_d     = '0;
                  half_d       = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         phase_q      <= '0;
         ph_cnt_q     <= '0;
         fr_tmr_q     <= '0;
         rel_cnt_q    <= '0;
         half_q       <= 1'b0;
         released_q   <= '0;
         frightened_q <= '0;
         move_q       <= '0;
      end else begin
         phase_q      <= phase_d;
         ph_cnt_q     <= ph_cnt_d;
         fr_tmr_q     <= fr_tmr_d;
         rel_cnt_q    <= rel_cnt_d;
         half_q       <= half_d;
         released_q   <= released_d;
         frightened_q <= frightened_d;
         move_q       <= move_d;
      end
   end

   assign move_en_o    = move_q;
   assign frightened_o = frightened_q;
   assign released_o   = released_q;

endmodule
